// File: rtl/operand_fetch_if.sv
// Bundle of decode, register-file, writeback, flush and execute signals around the operand fetch stage.
// Signal directions are named from the stage's point of view (slave = the stage itself).
interface operand_fetch_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            id_valid_i;
    logic            id_ready_o;
    logic [AW-1:0]   id_rs1_i;
    logic [AW-1:0]   id_rs2_i;
    logic [AW-1:0]   id_rd_i;
    logic            id_use_rs1_i;
    logic            id_use_rs2_i;
    logic            id_wr_rd_i;
    logic [XLEN-1:0] id_imm_i;
    logic [AW-1:0]   rf_addrs1_o;
    logic [AW-1:0]   rf_addrs2_o;
    logic [XLEN-1:0] rf_dators1_i;
    logic [XLEN-1:0] rf_dators2_i;
    logic [AW-1:0]   wb_addrrd_i;
    logic [XLEN-1:0] wb_datord_i;
    logic            wb_writeen_i;
    logic            flush_i;
    logic            ex_valid_o;
    logic            ex_ready_i;
    logic [XLEN-1:0] ex_op1_o;
    logic [XLEN-1:0] ex_op2_o;
    logic [XLEN-1:0] ex_imm_o;
    logic [AW-1:0]   ex_rd_o;
    logic            ex_wr_rd_o;

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
               id_wr_rd_i, id_imm_i, rf_dators1_i, rf_dators2_i, wb_addrrd_i,
               wb_datord_i, wb_writeen_i, flush_i, ex_ready_i,
        output id_ready_o, rf_addrs1_o, rf_addrs2_o, ex_valid_o, ex_op1_o, ex_op2_o,
               ex_imm_o, ex_rd_o, ex_wr_rd_o
    );

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
               id_wr_rd_i, id_imm_i, rf_dators1_i, rf_dators2_i, wb_addrrd_i,
               wb_datord_i, wb_writeen_i, flush_i, ex_ready_i,
        input  id_ready_o, rf_addrs1_o, rf_addrs2_o, ex_valid_o, ex_op1_o, ex_op2_o,
               ex_imm_o, ex_rd_o, ex_wr_rd_o
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read with writeback bypass, per-register pending scoreboard
// for RAW/WAW stalls, and a registered valid/ready output slot towards execute.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    operand_fetch_if.slave bus
);
    localparam int NREG = 2 ** AW;

    logic [NREG-1:0] pending_q, pending_d;
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_op1_q, ex_op1_d;
    logic [XLEN-1:0] ex_op2_q, ex_op2_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [AW-1:0]   ex_rd_q, ex_rd_d;
    logic            ex_wr_rd_q, ex_wr_rd_d;

    logic [XLEN-1:0] op1, op2;
    logic            raw_haz, waw_haz, slot, id_ready, fire;

    function automatic logic wbhit(input logic [AW-1:0] r, input logic we,
                                   input logic [AW-1:0] wa);
        return we && (wa == r) && (r != '0);
    endfunction

    function automatic logic [XLEN-1:0] resolve(input logic [AW-1:0] r,
                                                input logic [XLEN-1:0] rf,
                                                input logic we,
                                                input logic [AW-1:0] wa,
                                                input logic [XLEN-1:0] wd);
        if (r == '0) return '0;
        if (we && (wa == r)) return wd;
        return rf;
    endfunction

    assign bus.rf_addrs1_o = bus.id_rs1_i;
    assign bus.rf_addrs2_o = bus.id_rs2_i;

    // A source or destination whose writeback lands this cycle is no longer a hazard.
    always_comb begin
        op1     = resolve(bus.id_rs1_i, bus.rf_dators1_i, bus.wb_writeen_i, bus.wb_addrrd_i, bus.wb_datord_i);
        op2     = resolve(bus.id_rs2_i, bus.rf_dators2_i, bus.wb_writeen_i, bus.wb_addrrd_i, bus.wb_datord_i);
        raw_haz = (bus.id_use_rs1_i && (bus.id_rs1_i != '0) && pending_q[bus.id_rs1_i]
                   && !wbhit(bus.id_rs1_i, bus.wb_writeen_i, bus.wb_addrrd_i))
               || (bus.id_use_rs2_i && (bus.id_rs2_i != '0) && pending_q[bus.id_rs2_i]
                   && !wbhit(bus.id_rs2_i, bus.wb_writeen_i, bus.wb_addrrd_i));
        waw_haz = bus.id_wr_rd_i && (bus.id_rd_i != '0) && pending_q[bus.id_rd_i]
                   && !wbhit(bus.id_rd_i, bus.wb_writeen_i, bus.wb_addrrd_i);
        slot     = !ex_valid_q || bus.ex_ready_i;
        id_ready = rst_ni && slot && !raw_haz && !waw_haz && !bus.flush_i;
        fire     = bus.id_valid_i && id_ready;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_wr_rd_d = ex_wr_rd_q;
        pending_d  = pending_q;

        if (fire) begin
            ex_valid_d = 1'b1;
            ex_op1_d   = op1;
            ex_op2_d   = op2;
            ex_imm_d   = bus.id_imm_i;
            ex_rd_d    = bus.id_rd_i;
            ex_wr_rd_d = bus.id_wr_rd_i;
        end else if (bus.ex_ready_i || bus.flush_i) begin
            ex_valid_d = 1'b0;
        end

        if (wbhit(bus.wb_addrrd_i, bus.wb_writeen_i, bus.wb_addrrd_i))
            pending_d[bus.wb_addrrd_i] = 1'b0;
        // A killed writer will never write back, so release its destination now.
        if (bus.flush_i && ex_valid_q && ex_wr_rd_q)
            pending_d[ex_rd_q] = 1'b0;
        // Applied last so a new claim wins over a same-cycle release.
        if (fire && bus.id_wr_rd_i && (bus.id_rd_i != '0))
            pending_d[bus.id_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= '0;
            ex_valid_q <= 1'b0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_wr_rd_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_wr_rd_q <= ex_wr_rd_d;
        end
    end

    assign bus.id_ready_o = id_ready;
    assign bus.ex_valid_o = ex_valid_q;
    assign bus.ex_op1_o   = ex_op1_q;
    assign bus.ex_op2_o   = ex_op2_q;
    assign bus.ex_imm_o   = ex_imm_q;
    assign bus.ex_rd_o    = ex_rd_q;
    assign bus.ex_wr_rd_o = ex_wr_rd_q;
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute stage directly downstream of the register file.
- Drives the register file read addresses and captures the read data, with same-cycle writeback bypass.
- Tracks outstanding destination writes in a per-register scoreboard, stalls on RAW/WAW hazards, and presents operands to execute through a registered valid/ready interface.
- Register x0 is hardwired zero throughout.

Parameters:
- XLEN, 32, data width of operands, immediate and writeback data.
- AW, 5, register address width; scoreboard has 2**AW entries.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- id_valid_i  in  1  decoded instruction valid
- id_ready_o  out  1  stage accepts the instruction this cycle
- id_rs1_i  in  AW  source 1 index
- id_rs2_i  in  AW  source 2 index
- id_rd_i  in  AW  destination index
- id_use_rs1_i  in  1  instruction reads rs1
- id_use_rs2_i  in  1  instruction reads rs2
- id_wr_rd_i  in  1  instruction writes rd
- id_imm_i  in  XLEN  decoded immediate
- rf_addrs1_o  out  AW  register file read address 1
- rf_addrs2_o  out  AW  register file read address 2
- rf_dators1_i  in  XLEN  register file read data 1 (combinational)
- rf_dators2_i  in  XLEN  register file read data 2 (combinational)
- wb_addrrd_i  in  AW  writeback destination, the same net that feeds the register file
- wb_datord_i  in  XLEN  writeback data
- wb_writeen_i  in  1  writeback write enable
- flush_i  in  1  kill the instruction held in the output register
- ex_valid_o  out  1  operands valid to execute
- ex_ready_i  in  1  execute accepts
- ex_op1_o  out  XLEN  resolved source 1 value
- ex_op2_o  out  XLEN  resolved source 2 value
- ex_imm_o  out  XLEN  registered immediate
- ex_rd_o  out  AW  registered destination
- ex_wr_rd_o  out  1  registered write-rd flag

Behaviour:
- Reset (async, rst_ni=0):
  - All ex_* outputs are 0; scoreboard is all zeros.
  - id_ready_o is 0 while in reset.
- Read addresses: rf_addrs1_o = id_rs1_i and rf_addrs2_o = id_rs2_i, purely combinational.
- Operand resolve, per source X:
  - rsX==0 → 0.
  - else if wb_writeen_i && wb_addrrd_i==rsX → wb_datord_i (bypass).
  - else → rf_dotorsX_i.
- Writeback hit: wbhit(r) = wb_writeen_i && wb_addrrd_i==r && r!=0.
- RAW hazard: id_use_rsX_i && rsX!=0 && pending[rsX] && !wbhit(rsX), for either source.
- WAW hazard: id_wr_rd_i && rd!=0 && pending[rd] && !wbhit(rd).
- Output slot free: slot = !ex_valid_o || ex_ready_i.
- id_ready_o = slot && !hazard && !flush_i. fire = id_valid_i && id_ready_o.
- Output register update:
  - fire → load op1, op2, imm, rd, wr_rd; ex_valid_o=1.
  - else if ex_ready_i or flush_i → ex_valid_o=0.
  - otherwise hold. ex_* data is stable while ex_valid_o && !ex_ready_i.
- Scoreboard:
  - Clear pending[wb_addrrd_i] when wbhit.
  - Set pending[id_rd_i] on fire && id_wr_rd_i && id_rd_i!=0.
  - Set wins over clear on the same index in the same cycle.
  - Writes to x0 never set a bit; a clear of a non-pending bit has no effect.
- Flush:
  - ex_valid_o clears next cycle.
  - If ex_valid_o && ex_wr_rd_o, pending[ex_rd_o] is cleared, because the killed instruction never writes back.
  - No new instruction is accepted in the flush cycle.
- Latency: one cycle from fire to ex_valid_o. Full throughput (one per cycle) with no hazards and ex_ready_i held high.
- Back-pressure: with ex_valid_o=1 and ex_ready_i=0, id_ready_o=0 and the output register holds.

Test Plan:
- Reset, then issue three independent instructions back-to-back with ex_ready_i=1 and rf data 0x11/0x22 → ex_valid_o high on cycles 1-3, op values correct, id_ready_o stays 1.
- Issue rd=5 writer, then a reader with rs1=5 → reader stalls (id_ready_o=0). Then wb_writeen_i=1, wb_addrrd_i=5, wb_datord_i=0xDEADBEEF → reader fires the same cycle with ex_op1_o=0xDEADBEEF the next cycle, and pending[5] ends at 0.
- WAW: writer rd=7 pending, second writer rd=7 → stalls until wb to r7. In the release cycle both the clear and the new set land, and pending[7]=1.
- Source x0 with rf_dators1_i=0xFFFFFFFF and wb write to 0 → ex_op1_o=0, and no scoreboard bit is set for rd=0.
- Hold ex_ready_i=0 for 4 cycles → ex_* stable and id_ready_o=0. Release → next instruction fires in the same cycle.
- Flush with a writer rd=9 in the output register → ex_valid_o=0 next cycle, pending[9]=0, and a following reader of r9 issues without stall. An async reset mid-stall returns all outputs and the scoreboard to 0.
